// File: rtl/interface2_rd_pkg.sv
// Shared FFT data-memory definitions: lane geometry, rotation and destination
// encodings, and the lane-index helper used by both PERMW and PERMR.
package interface2_rd_pkg;

  localparam int DW        = 64;
  localparam int NUM_LANES = 4;

  typedef logic [1:0] rot_t;

  typedef enum logic {
    DST_EXTN = 1'b0,
    DST_HRMF = 1'b1
  } dst_t;

  // One read request travelling alongside the bank read latency.
  typedef struct packed {
    logic valid;
    rot_t rot;
    dst_t dst;
  } tag_t;

  // Bank feeding lane i for a given rotation; 2-bit arithmetic wraps mod 4.
  function automatic logic [1:0] lane_idx(input logic [1:0] i, input rot_t rot);
    return i + rot;
  endfunction

endpackage

// File: rtl/interface2_rd_permr.sv
// PERMR: combinational inverse of the write-side lane rotation,
// out_i = D[(i + SEL) mod 4].
module interface2_rd_permr #(
  parameter int DW = interface2_rd_pkg::DW
) (
  input  logic [1:0]    SEL,
  input  logic [DW-1:0] D0,
  input  logic [DW-1:0] D1,
  input  logic [DW-1:0] D2,
  input  logic [DW-1:0] D3,
  output logic [DW-1:0] Q0,
  output logic [DW-1:0] Q1,
  output logic [DW-1:0] Q2,
  output logic [DW-1:0] Q3
);
  import interface2_rd_pkg::*;

  logic [DW-1:0] d [NUM_LANES];
  logic [DW-1:0] q [NUM_LANES];

  assign d[0] = D0;
  assign d[1] = D1;
  assign d[2] = D2;
  assign d[3] = D3;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign q[i] = d[lane_idx(2'(i), SEL)];
  end

  assign Q0 = q[0];
  assign Q1 = q[1];
  assign Q2 = q[2];
  assign Q3 = q[3];

endmodule

// File: rtl/interface2_rd.sv
// Read-side interface of the 4-bank FFT data memory: credit-gated request
// issue, tag tracking through the read latency, PERMR and an in-order output FIFO.
module interface2_rd #(
  parameter int DW         = interface2_rd_pkg::DW,
  parameter int AW         = 8,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 5
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          REQ_VALID,
  output logic          REQ_READY,
  input  logic [AW-1:0] REQ_ADDR,
  input  logic [1:0]    REQ_ROT,
  input  logic          REQ_DST,
  output logic          MEM_RE,
  output logic [AW-1:0] MEM_ADDR,
  input  logic [DW-1:0] MEM_Q0,
  input  logic [DW-1:0] MEM_Q1,
  input  logic [DW-1:0] MEM_Q2,
  input  logic [DW-1:0] MEM_Q3,
  output logic [DW-1:0] Q0,
  output logic [DW-1:0] Q1,
  output logic [DW-1:0] Q2,
  output logic [DW-1:0] Q3,
  output logic          EXTN_VALID,
  input  logic          EXTN_READY,
  output logic          HRMF_VALID,
  input  logic          HRMF_READY
);
  import interface2_rd_pkg::*;

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_LAST   = PW'(FIFO_DEPTH - 1);

  typedef struct packed {
    dst_t                         dst;
    logic [NUM_LANES-1:0][DW-1:0] row;
  } entry_t;

  // Request issue and credits
  logic          accept;
  logic          mem_re_q, mem_re_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [CW-1:0] credit_q, credit_d;

  // Tag pipeline, index RD_LAT lines up with MEM_Q
  tag_t tag_q [RD_LAT+1];
  tag_t tag_d [RD_LAT+1];
  tag_t tag_out;

  // Output FIFO
  entry_t        fifo_mem_q [FIFO_DEPTH];
  entry_t        push_entry;
  entry_t        head;
  logic          push, pop, head_valid;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] perm_q [NUM_LANES];

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign REQ_READY = (credit_q != '0);
  assign accept    = REQ_VALID && REQ_READY;

  assign tag_out    = tag_q[RD_LAT];
  assign push       = tag_out.valid;
  assign head_valid = (count_q != '0);
  assign head       = fifo_mem_q[rd_ptr_q];
  assign pop        = head_valid && ((head.dst == DST_HRMF) ? HRMF_READY : EXTN_READY);

  interface2_rd_permr #(.DW(DW)) u_permr (
    .SEL (tag_out.rot),
    .D0  (MEM_Q0),
    .D1  (MEM_Q1),
    .D2  (MEM_Q2),
    .D3  (MEM_Q3),
    .Q0  (perm_q[0]),
    .Q1  (perm_q[1]),
    .Q2  (perm_q[2]),
    .Q3  (perm_q[3])
  );

  assign push_entry = '{dst: tag_out.dst,
                        row: {perm_q[3], perm_q[2], perm_q[1], perm_q[0]}};

  always_comb begin
    // NOTE: every _d signal takes a default before any condition so no latch is inferred.
    mem_re_d   = accept;
    mem_addr_d = mem_addr_q;
    credit_d   = credit_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (accept) begin
      mem_addr_d = REQ_ADDR;
    end

    tag_d[0] = '{valid: accept, rot: REQ_ROT, dst: dst_t'(REQ_DST)};
    for (int k = 1; k <= RD_LAT; k++) begin
      tag_d[k] = tag_q[k-1];
    end

    // A credit is held from accept until the row leaves the FIFO.
    case ({accept, pop})
      2'b10:   credit_d = credit_q - CW'(1);
      2'b01:   credit_d = credit_q + CW'(1);
      default: credit_d = credit_q;
    endcase

    if (push) begin
      wr_ptr_d = ptr_next(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_next(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      mem_re_q   <= 1'b0;
      mem_addr_q <= '0;
      credit_q   <= CREDIT_MAX;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int k = 0; k <= RD_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      mem_re_q   <= mem_re_d;
      mem_addr_q <= mem_addr_d;
      credit_q   <= credit_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      for (int k = 0; k <= RD_LAT; k++) begin
        tag_q[k] <= tag_d[k];
      end
    end
  end

  // NOTE: FIFO storage has no reset; the occupancy count gates the outputs,
  // so stale rows are never visible.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= push_entry;
    end
  end

  assign MEM_RE     = mem_re_q;
  assign MEM_ADDR   = mem_addr_q;
  assign Q0         = head_valid ? head.row[0] : '0;
  assign Q1         = head_valid ? head.row[1] : '0;
  assign Q2         = head_valid ? head.row[2] : '0;
  assign Q3         = head_valid ? head.row[3] : '0;
  assign EXTN_VALID = head_valid && (head.dst == DST_EXTN);
  assign HRMF_VALID = head_valid && (head.dst == DST_HRMF);

endmodule

// File: tb/tb_interface2_rd.sv
// Scoreboard bench for interface2_rd with a 2-cycle-latency 4-bank memory model.
module tb_interface2_rd;

  localparam int DW         = 64;
  localparam int AW         = 8;
  localparam int RD_LAT     = 2;
  localparam int FIFO_DEPTH = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid, req_ready, req_dst;
  logic [AW-1:0] req_addr;
  logic [1:0]    req_rot;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_q [4] = '{default: '0};
  logic [DW-1:0] q0, q1, q2, q3;
  logic          extn_valid, extn_ready, hrmf_valid, hrmf_ready;

  always #5 clk = ~clk;

  interface2_rd #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .CLK        (clk),
    .RSTN       (rst_n),
    .REQ_VALID  (req_valid),
    .REQ_READY  (req_ready),
    .REQ_ADDR   (req_addr),
    .REQ_ROT    (req_rot),
    .REQ_DST    (req_dst),
    .MEM_RE     (mem_re),
    .MEM_ADDR   (mem_addr),
    .MEM_Q0     (mem_q[0]),
    .MEM_Q1     (mem_q[1]),
    .MEM_Q2     (mem_q[2]),
    .MEM_Q3     (mem_q[3]),
    .Q0         (q0),
    .Q1         (q1),
    .Q2         (q2),
    .Q3         (q3),
    .EXTN_VALID (extn_valid),
    .EXTN_READY (extn_ready),
    .HRMF_VALID (hrmf_valid),
    .HRMF_READY (hrmf_ready)
  );

  typedef struct packed {
    logic               dst;
    logic [3:0][DW-1:0] q;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pop_cnt = 0;
  int   last_pop_cyc = 0;

  function automatic logic [DW-1:0] bank_word(input int b, input logic [AW-1:0] a);
    if (a == 8'h12) return 64'hA + 64'(b);
    return {16'hB000 + 16'(b), 40'h0, a};
  endfunction

  function automatic exp_t expect_row(input logic [AW-1:0] a, input logic [1:0] rot,
                                      input logic dst);
    exp_t e;
    e.dst = dst;
    for (int i = 0; i < 4; i++) e.q[i] = bank_word((i + int'(rot)) % 4, a);
    return e;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Bank model: address captured on the MEM_RE cycle, data valid RD_LAT cycles later.
  logic          re_p1 = 1'b0;
  logic [AW-1:0] addr_p1 = '0;
  always @(posedge clk) begin
    re_p1   <= mem_re;
    addr_p1 <= mem_addr;
    if (re_p1) begin
      for (int b = 0; b < 4; b++) mem_q[b] <= bank_word(b, addr_p1);
    end
  end

  // Scoreboard: push on accept, pop and compare on every output handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (extn_valid || hrmf_valid)
        check("valid_onehot", 64'(extn_valid && hrmf_valid), 64'd0);
      if ((extn_valid && extn_ready) || (hrmf_valid && hrmf_ready)) begin
        pop_cnt      <= pop_cnt + 1;
        last_pop_cyc <= cyc;
        if (sb.size() == 0) begin
          check("unexpected_output", 64'd1, 64'd0);
        end else begin
          check("out_dst", 64'(hrmf_valid), 64'(sb[0].dst));
          check("out_q0", q0, sb[0].q[0]);
          check("out_q1", q1, sb[0].q[1]);
          check("out_q2", q2, sb[0].q[2]);
          check("out_q3", q3, sb[0].q[3]);
          void'(sb.pop_front());
        end
      end
      if (req_valid && req_ready) sb.push_back(expect_row(req_addr, req_rot, req_dst));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [AW-1:0] a, input logic [1:0] rot, input logic dst);
    req_valid = 1'b1;
    req_addr  = a;
    req_rot   = rot;
    req_dst   = dst;
  endtask

  task automatic wait_drain(input string tag, input int max_cycles);
    int n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    check(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, base_pops, accepted;
    logic any_valid;

    req_valid = 1'b0; req_addr = '0; req_rot = '0; req_dst = 1'b0;
    extn_ready = 1'b0; hrmf_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_mem_re", 64'(mem_re), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_extn_valid", 64'(extn_valid), 64'd0);
    check("rst_hrmf_valid", 64'(hrmf_valid), 64'd0);
    check("rst_q0", q0, 64'd0);
    check("rst_q3", q3, 64'd0);

    // Single request, latency and de-rotation
    extn_ready = 1'b1; hrmf_ready = 1'b1;
    drive_req(8'h12, 2'd1, 1'b1);
    tick();
    req_valid = 1'b0;
    check("t2_mem_re", 64'(mem_re), 64'd1);
    check("t2_mem_addr", 64'(mem_addr), 64'h12);
    tick();
    tick();
    check("t2_early_valid", 64'(hrmf_valid), 64'd0);
    tick();
    check("t2_hrmf_valid", 64'(hrmf_valid), 64'd1);
    check("t2_extn_valid", 64'(extn_valid), 64'd0);
    check("t2_q0", q0, 64'hB);
    check("t2_q1", q1, 64'hC);
    check("t2_q2", q2, 64'hD);
    check("t2_q3", q3, 64'hA);
    tick();

    // Back-to-back at full rate
    c0 = cyc;
    base_pops = pop_cnt;
    for (int i = 0; i < 8; i++) begin
      drive_req(8'(8'h20 + i), 2'(i), 1'(i));
      check("t3_req_ready", 64'(req_ready), 64'd1);
      tick();
    end
    req_valid = 1'b0;
    repeat (6) tick();
    check("t3_pops", 64'(pop_cnt - base_pops), 64'd8);
    check("t3_last_pop_cycle", 64'(last_pop_cyc - c0), 64'd11);

    // Credit exhaustion with a stalled external consumer
    extn_ready = 1'b0;
    accepted = 0;
    base_pops = pop_cnt;
    for (int i = 0; i < 8; i++) begin
      drive_req(8'(8'h40 + i), 2'(i + 1), 1'b0);
      if (req_ready) accepted++;
      tick();
    end
    req_valid = 1'b0;
    check("t4_accepted", 64'(accepted), 64'(FIFO_DEPTH));
    check("t4_req_ready_full", 64'(req_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      check("t4_hold_q0", q0, sb[0].q[0]);
      check("t4_hold_valid", 64'(extn_valid), 64'd1);
      tick();
    end
    extn_ready = 1'b1;
    check("t4_ready_at_pop", 64'(req_ready), 64'd0);
    tick();
    check("t4_ready_after_pop", 64'(req_ready), 64'd1);
    wait_drain("t4_drain", 20);
    check("t4_pops", 64'(pop_cnt - base_pops), 64'(FIFO_DEPTH));

    // Head-of-line blocking across destinations
    extn_ready = 1'b1; hrmf_ready = 1'b0;
    base_pops = pop_cnt;
    for (int i = 0; i < 4; i++) begin
      drive_req(8'(8'h60 + i), 2'(3 - i), 1'(~i[0]));
      tick();
    end
    req_valid = 1'b0;
    repeat (6) tick();
    check("t5_stall_pops", 64'(pop_cnt - base_pops), 64'd0);
    check("t5_hrmf_valid", 64'(hrmf_valid), 64'd1);
    check("t5_extn_blocked", 64'(extn_valid), 64'd0);
    hrmf_ready = 1'b1;
    wait_drain("t5_drain", 20);
    check("t5_pops", 64'(pop_cnt - base_pops), 64'd4);

    // Reset with rows buffered and reads in flight
    extn_ready = 1'b0; hrmf_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_req(8'(8'h80 + i), 2'(i), 1'b0);
      tick();
    end
    req_valid = 1'b0;
    repeat (5) tick();
    for (int i = 2; i < 4; i++) begin
      drive_req(8'(8'h80 + i), 2'(i), 1'b0);
      tick();
    end
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_rst_extn_valid", 64'(extn_valid), 64'd0);
    check("t6_rst_hrmf_valid", 64'(hrmf_valid), 64'd0);
    check("t6_rst_q0", q0, 64'd0);
    check("t6_rst_mem_re", 64'(mem_re), 64'd0);
    tick();
    rst_n = 1'b1;
    check("t6_req_ready", 64'(req_ready), 64'd1);
    any_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (extn_valid || hrmf_valid) any_valid = 1'b1;
      tick();
    end
    check("t6_no_stale_valid", 64'(any_valid), 64'd0);
    accepted = 0;
    for (int i = 0; i < 7; i++) begin
      drive_req(8'(8'hA0 + i), 2'(i), 1'(i));
      if (req_ready) accepted++;
      tick();
    end
    req_valid = 1'b0;
    check("t6_credits", 64'(accepted), 64'(FIFO_DEPTH));
    extn_ready = 1'b1; hrmf_ready = 1'b1;
    wait_drain("t6_drain", 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/interface2_rd.md
Name: interface2_rd

Overview:
- Read-side counterpart of the write interface (ext/HRMF source mux plus PERMW lane rotation) in front of the 4-bank FFT data memory.
- Accepts read requests carrying a bank address, the rotation used at write time and a destination. Issues bank reads and tracks each request through the memory read latency.
- Undoes the write rotation (PERMR) on the returned data.
- Buffers results in a credit-controlled FIFO and delivers them to the external or the HRMF consumer with valid/ready.

Parameters:
- DW, 64, lane data width.
- AW, 8, bank address width.
- RD_LAT, 2, bank read latency in cycles from MEM_RE to MEM_Q valid; must be >= 1.
- FIFO_DEPTH, 5, output buffer entries; must be >= 2. Full rate requires FIFO_DEPTH >= RD_LAT+3.

Ports:
- CLK  in  1  clock
- RSTN  in  1  reset, asynchronous, active-low
- REQ_VALID  in  1  read request valid
- REQ_READY  out  1  request accepted when REQ_VALID && REQ_READY
- REQ_ADDR  in  AW  common address for all 4 banks
- REQ_ROT  in  2  rotation (SEL_PERMW value) used when the row was written
- REQ_DST  in  1  0 = external consumer, 1 = HRMF consumer (mirrors SEL_EXTN)
- MEM_RE  out  1  bank read enable, all 4 banks
- MEM_ADDR  out  AW  bank read address
- MEM_Q0..MEM_Q3  in  DW each  bank 0..3 read data
- Q0..Q3  out  DW each  de-rotated lane data, shared by both consumers
- EXTN_VALID  out  1  Q valid for the external consumer
- EXTN_READY  in  1  external consumer ready
- HRMF_VALID  out  1  Q valid for the HRMF consumer
- HRMF_READY  in  1  HRMF consumer ready

Behaviour:
- **Reset (RSTN low, async):**
  - MEM_RE=0, MEM_ADDR=0, Q0..Q3=0, EXTN_VALID=0, HRMF_VALID=0.
  - FIFO emptied, tag pipeline cleared, credit counter set to FIFO_DEPTH.
  - REQ_READY=1 immediately after reset.
- **Credits:**
  - credits = FIFO_DEPTH − (in-flight tags + FIFO occupancy).
  - REQ_READY = (credits != 0), driven combinationally from the registered counter.
  - Accept decrements credits; pop increments them. Both in the same cycle leaves credits unchanged.
  - Credits never go below 0 or above FIFO_DEPTH.
- **Issue:** on accept at cycle t, MEM_RE=1 and MEM_ADDR=REQ_ADDR are registered and appear at t+1. With no accept, MEM_RE=0 and MEM_ADDR holds its value.
- **Tag pipeline:**
  - {valid, rot, dst} is shifted RD_LAT+1 stages, aligned so the tag emerges in the cycle MEM_Q is valid (t+1+RD_LAT).
  - MEM_Q is sampled only when the emerging tag is valid.
- **Inverse permutation (PERMR):** out_i = MEM_Q[(i+rot) mod 4].
  - rot 0: {Q0,Q1,Q2,Q3} = {B0,B1,B2,B3}
  - rot 1: {B1,B2,B3,B0}
  - rot 2: {B2,B3,B0,B1}
  - rot 3: {B3,B0,B1,B2}
- **Push:** the de-rotated row plus dst is written to the FIFO at the end of cycle t+1+RD_LAT. Push never finds the FIFO full; credits guarantee a free slot.
- **Output:**
  - The FIFO head drives Q0..Q3, registered with no bypass. First output valid is at t+2+RD_LAT.
  - EXTN_VALID = head_valid && !dst. HRMF_VALID = head_valid && dst. Never both high.
  - Pop when the selected valid and its ready are both high.
  - Q and VALID hold stable while valid && !ready. The non-selected consumer's ready is ignored.
  - Results leave in strict request order, including across dst switches (no reordering). Q0..Q3=0 when empty.
- **Simultaneous push and pop:** allowed in any state, including full with pop (occupancy unchanged) and empty with push (the pushed row becomes the head next cycle).
- **Reset mid-operation:** in-flight reads and buffered rows are discarded. MEM_Q returning after reset is ignored because its tags are cleared.
- **Widths:** pointers are clog2(FIFO_DEPTH) bits with explicit wrap at FIFO_DEPTH−1→0 (depth need not be a power of 2). The counter is clog2(FIFO_DEPTH+1) bits.

Decomposition:
- Shared FFT package holds DW=64, NUM_LANES=4, the rotation type (2-bit), the dst encoding (DST_EXTN=0, DST_HRMF=1), and a lane-index function (i+rot) mod 4 shared with PERMW.
- Sub-module `permr`: combinational inverse rotator (SEL, D0..D3 → Q0..Q3), instantiated once.
- FIFO, tag pipeline and credit counter stay inline.

Test Plan:
1. Assert RSTN=0 and release → all outputs 0, REQ_READY=1, MEM_RE=0.
2. One request at t with ADDR=0x12, ROT=1, DST=1; banks return B0..B3 = 0xA,0xB,0xC,0xD at t+3; HRMF_READY=1 → MEM_RE=1 and MEM_ADDR=0x12 at t+1; HRMF_VALID=1 and Q={0xB,0xC,0xD,0xA} at t+4; EXTN_VALID=0.
3. FIFO_DEPTH=5, RD_LAT=2: 8 back-to-back requests with ROT cycling 0..3 and both readies high → 8 consecutive outputs with no bubbles, each correctly de-rotated, REQ_READY constantly 1.
4. EXTN_READY=0 with continuous DST=0 requests → exactly 5 accepted, then REQ_READY=0. Q holds row 0 stable. Raise EXTN_READY → rows 0..4 drain in order and REQ_READY returns 1 one cycle after the first pop.
5. Alternate DST 0/1 with HRMF_READY=0 and EXTN_READY=1 → the head (DST=1) stalls the following DST=0 row; no reordering; the EXTN row appears only after HRMF_READY rises.
6. Pulse RSTN low with 2 reads in flight and 2 rows buffered → outputs 0 at once, stale MEM_Q returns produce no valid, credits=5 after release.
